// File: rtl/zorro_autoconfig_if.sv
// zorro_autoconfig_if
//   68030-side bus bundle seen by the Zorro II autoconfig / fast RAM decode
//   stage.
//   master : CPU side; drives the strobes, function code, address and write
//            data, and observes the decode results.
//   slave  : the decode stage (zorro_autoconfig).
//   AS20, DS20      address / data strobe, active low
//   RW20            1 = read, 0 = write
//   FC[2:0]         function code (3'b111 = CPU space)
//   A[23:0]         address bus
//   D_IN[3:0]       write data nibble D31:28
//   D_OUT[3:0]      read data nibble D31:28
//   D_OE            1 = D_OUT drives D31:28
//   INTCYCLE        0 = internal access; the bus bridge stays idle
//   RAMSEL          0 = fast RAM hit
//   DSACK1          0 = config cycle terminated as a 16-bit port
interface zorro_autoconfig_if;
   logic        AS20;
   logic        DS20;
   logic        RW20;
   logic [2:0]  FC;
   logic [23:0] A;
   logic [3:0]  D_IN;
   logic [3:0]  D_OUT;
   logic        D_OE;
   logic        INTCYCLE;
   logic        RAMSEL;
   logic        DSACK1;

   modport master (
      output AS20, DS20, RW20, FC, A, D_IN,
      input  D_OUT, D_OE, INTCYCLE, RAMSEL, DSACK1
   );

   modport slave (
      input  AS20, DS20, RW20, FC, A, D_IN,
      output D_OUT, D_OE, INTCYCLE, RAMSEL, DSACK1
   );
endinterface

// File: rtl/zorro_autoconfig.sv
// zorro_autoconfig
//   Upstream decode stage for the 68030-to-Amiga bus bridge. Presents a
//   Zorro II autoconfig board for the accelerator fast RAM, records the base
//   address the OS assigns, decodes fast RAM hits and terminates config-space
//   cycles internally. INTCYCLE (active low) tells the bus bridge to keep the
//   Amiga bus idle.
// Ports
//   CLKCPU   in   CPU clock, all flops on its rising edge
//   RESET    in   asynchronous, active-high reset
//   bus      slave modport of zorro_autoconfig_if (strobes, FC, address,
//            data nibble D31:28, D_OE, INTCYCLE, RAMSEL, DSACK1)
//   CFGIN    in   (ZORRO_CFGOUT_EN only) chain enable from upstream, active low
//   CFGOUT   out  (ZORRO_CFGOUT_EN only) chain enable to downstream, active low
// Configuration
//   ZORRO_CFGOUT_EN : when defined, adds CFGIN/CFGOUT for daisy-chained
//   autoconfig. When undefined, the board is always first in the chain.
module zorro_autoconfig #(
   parameter logic [7:0]  PRODUCT      = 8'h03,
   parameter logic [15:0] MANUFACTURER = 16'h07DB,
   parameter int          RAM_MB       = 8,
   parameter int          CFG_WAIT     = 2
) (
   input  logic CLKCPU,
   input  logic RESET,
`ifdef ZORRO_CFGOUT_EN
   input  logic CFGIN,
   output logic CFGOUT,
`endif
   zorro_autoconfig_if.slave bus
);

   typedef enum logic [1:0] {
      UNCONF     = 2'd0,
      CONFIGURED = 2'd1,
      SHUTUP     = 2'd2
   } board_t;

   typedef enum logic [1:0] {
      CYC_IDLE = 2'd0,
      CYC_WAIT = 2'd1,
      CYC_ACK  = 2'd2
   } cyc_t;

   localparam logic [2:0] CNT_LAST = 3'(CFG_WAIT - 1);
   localparam logic [4:0] RAM_SPAN = 5'(RAM_MB);

   // Board state: cleared only by RESET.
   board_t     board_reg, board_next;
   logic [3:0] base_reg, base_next;
   logic       pend_cfg_reg, pend_cfg_next;
   logic       pend_shut_reg, pend_shut_next;
   logic [3:0] er_low_unused_reg, er_low_unused_next;

   // Cycle state: cleared by RESET or by AS20 going high.
   cyc_t       cyc_reg, cyc_next;
   logic [2:0] cnt_reg, cnt_next;
   logic       intcycle_reg, intcycle_next;

   logic       cycle_clr;
   logic       cfgin_n;
   logic       cfg_hit;
   logic       ram_hit;
   logic       data_space;
   logic [4:0] page;
   logic [4:0] range_lo;
   logic [4:0] range_hi;
   logic [3:0] rom_nib;
   logic       wr_strobe;
   logic       unused_addr;

`ifdef ZORRO_CFGOUT_EN
   logic cfgout_reg;
   assign cfgin_n = CFGIN;
   assign CFGOUT  = cfgout_reg;
`else
   assign cfgin_n = 1'b0;
`endif

   assign cycle_clr  = RESET | bus.AS20;
   assign data_space = ~bus.AS20 & ~(&bus.FC);
   assign wr_strobe  = ~bus.RW20 & ~bus.DS20;

   assign cfg_hit = (board_reg == UNCONF) & data_space & ~cfgin_n &
                    (bus.A[23:16] == 8'hE8);

   // 5-bit compare so a board placed near the top of the map cannot wrap
   // around to $0.
   assign page     = {1'b0, bus.A[23:20]};
   assign range_lo = {1'b0, base_reg};
   assign range_hi = range_lo + RAM_SPAN - 5'd1;
   assign ram_hit  = (board_reg == CONFIGURED) & data_space &
                     (page >= range_lo) & (page <= range_hi);

   // Only A[6:1] selects a config register; the rest are don't-care here.
   assign unused_addr = ^{bus.A[15:7], bus.A[0]};

   // Autoconfig read map; everything except $00/$02 is stored inverted.
   always_comb begin
      rom_nib = 4'hF;
      case (bus.A[6:1])
         6'h00:   rom_nib = 4'hE;
         6'h01:   rom_nib = 4'h0;
         6'h02:   rom_nib = ~PRODUCT[7:4];
         6'h03:   rom_nib = ~PRODUCT[3:0];
         6'h08:   rom_nib = ~MANUFACTURER[15:12];
         6'h09:   rom_nib = ~MANUFACTURER[11:8];
         6'h0A:   rom_nib = ~MANUFACTURER[7:4];
         6'h0B:   rom_nib = ~MANUFACTURER[3:0];
         default: rom_nib = 4'hF;
      endcase
   end

   always_comb begin
      cyc_next           = cyc_reg;
      cnt_next           = cnt_reg;
      intcycle_next      = intcycle_reg;
      board_next         = board_reg;
      base_next          = base_reg;
      pend_cfg_next      = pend_cfg_reg;
      pend_shut_next     = pend_shut_reg;
      er_low_unused_next = er_low_unused_reg;

      case (cyc_reg)
         CYC_IDLE: begin
            if (cfg_hit) begin
               cyc_next = CYC_WAIT;
               cnt_next = 3'd0;
            end
         end
         CYC_WAIT: begin
            if (cnt_reg == CNT_LAST) begin
               cyc_next = CYC_ACK;
               // Writes are captured once, on the edge that terminates.
               if (wr_strobe) begin
                  case (bus.A[6:1])
                     6'h24: begin
                        base_next     = bus.D_IN;
                        pend_cfg_next = 1'b1;
                     end
                     6'h25:   er_low_unused_next = bus.D_IN;
                     6'h26:   pend_shut_next     = 1'b1;
                     default: ;
                  endcase
               end
            end else begin
               cnt_next = cnt_reg + 3'd1;
            end
         end
         CYC_ACK:  ;
         default:  cyc_next = CYC_IDLE;
      endcase

      if (cfg_hit || ram_hit) begin
         intcycle_next = 1'b0;
      end

      // A pending state change is applied only once the config cycle has
      // ended, so the new RAM window cannot alias the cycle still in flight.
      if ((cyc_reg == CYC_IDLE) && (pend_cfg_reg || pend_shut_reg)) begin
         pend_cfg_next  = 1'b0;
         pend_shut_next = 1'b0;
         if (board_reg == UNCONF) begin
            board_next = pend_shut_reg ? SHUTUP : CONFIGURED;
         end
      end
   end

   always_ff @(posedge CLKCPU or posedge cycle_clr) begin
      if (cycle_clr) begin
         cyc_reg      <= CYC_IDLE;
         cnt_reg      <= 3'd0;
         intcycle_reg <= 1'b1;
      end else begin
         cyc_reg      <= cyc_next;
         cnt_reg      <= cnt_next;
         intcycle_reg <= intcycle_next;
      end
   end

   always_ff @(posedge CLKCPU or posedge RESET) begin
      if (RESET) begin
         board_reg         <= UNCONF;
         base_reg          <= 4'h0;
         pend_cfg_reg      <= 1'b0;
         pend_shut_reg     <= 1'b0;
         er_low_unused_reg <= 4'h0;
      end else begin
         board_reg         <= board_next;
         base_reg          <= base_next;
         pend_cfg_reg      <= pend_cfg_next;
         pend_shut_reg     <= pend_shut_next;
         er_low_unused_reg <= er_low_unused_next;
      end
   end

`ifdef ZORRO_CFGOUT_EN
   // Pass the chain on one edge after this board leaves UNCONF.
   always_ff @(posedge CLKCPU or posedge RESET) begin
      if (RESET) begin
         cfgout_reg <= 1'b1;
      end else begin
         cfgout_reg <= (board_reg == UNCONF);
      end
   end
`endif

   assign bus.D_OE     = ((cyc_reg == CYC_WAIT) || (cyc_reg == CYC_ACK)) & bus.RW20;
   assign bus.D_OUT    = bus.D_OE ? rom_nib : 4'hF;
   assign bus.DSACK1   = ~(cyc_reg == CYC_ACK);
   assign bus.INTCYCLE = intcycle_reg;
   assign bus.RAMSEL   = ~ram_hit;

endmodule
